rom_loader: RTL

Synthesizable boot loader for the miniRV SoC. It receives a program image over a UART serial line, packs the bytes into 32-bit little-endian words and writes them through the instruction ROM's write port from address 0 upward. The CPU is held in reset until the image is complete. This replaces the simulation-only backdoor load of `inst.data` with a hardware path usable on silicon and FPGA.

---
 rtl/rom_loader_pkg.sv | 30 +++
 rtl/rom_loader_uart_rx.sv | 102 ++++++++++
 rtl/rom_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// ============================================================================
// rom_loader_pkg: shared sync byte and FSM encodings for the UART ROM loader.
// rev 1.0
// ============================================================================
`default_nettype none

package rom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/rom_loader_uart_rx.sv
// ============================================================================
// uart_rx: 8N1 receiver with glitch-rejecting start bit and stop-bit check.
// rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import rom_loader_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int            CW     = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] C_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2 - 1);

  logic            meta_q, sync_q, prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta_q       <= 1'b1;
      sync_q       <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      meta_q       <= rxd;
      sync_q       <= meta_q;
      prev_q       <= sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_q == C_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == C_FULL) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == C_FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync_q) byte_valid_d = 1'b1;
          else        frame_err_d  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: rtl/rom_loader.sv
// ============================================================================
// rom_loader: UART boot loader writing a framed image into instruction ROM.
// Optional trailing checksum byte enabled by ROM_LOADER_CHECKSUM_EN. rev 1.0
// ============================================================================
`default_nettype none

module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int BAUD_DIV = 868,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              uart_rxd,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_rst_b,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [16:0]   C_CAP = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] C_ONE = (ADDR_W + 1)'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam ld_state_t     C_END = ST_CSUM;
`else
  localparam ld_state_t     C_END = ST_DONE;
`endif

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst_b      (rst_b),
    .rxd        (uart_rxd),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_ferr)
  );

  ld_state_t         state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]       rom_wdata_q, rom_wdata_d;
  logic              cpu_rst_b_q, cpu_rst_b_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [15:0] w_len;
  logic        w_is_sync;
  logic        w_last_word;

  assign w_len       = {rx_data, len_lo_q};
  assign w_is_sync   = rx_valid && (rx_data == SYNC_BYTE);
  assign w_last_word = (addr_q + C_ONE) == n_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_rst_b_q <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_rst_b_q <= cpu_rst_b_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    n_d         = n_q;
    addr_d      = addr_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    cpu_rst_b_d = cpu_rst_b_q;
    busy_d      = busy_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (state_q == ST_ERR) begin
          load_err_d = 1'b1;
          busy_d     = 1'b0;
        end
        // A sync byte always starts a fresh frame from word 0.
        if (w_is_sync) begin
          state_d    = ST_LEN0;
          busy_d     = 1'b1;
          load_err_d = 1'b0;
          addr_d     = '0;
          byte_idx_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_LEN0: begin
        if (rx_valid) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (rx_valid) begin
          n_d = w_len[ADDR_W:0];
          if ({1'b0, w_len} > C_CAP) state_d = ST_ERR;
          else if (w_len == 16'd0)   state_d = C_END;
          else                       state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          csum_d = csum_q + rx_data;
`endif
          byte_idx_d = byte_idx_q + 2'd1;
          word_d     = {rx_data, word_q[23:8]};
          if (byte_idx_q == 2'd3) begin
            rom_we_d    = 1'b1;
            rom_addr_d  = addr_q[ADDR_W-1:0];
            rom_wdata_d = {rx_data, word_q};
            addr_d      = addr_q + C_ONE;
            if (w_last_word) state_d = C_END;
          end
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: begin
        load_done_d = 1'b1;
        cpu_rst_b_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rx_ferr && (state_q == ST_LEN0 || state_q == ST_LEN1 ||
                    state_q == ST_DATA || state_q == ST_CSUM))
      state_d = ST_ERR;
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_rst_b = cpu_rst_b_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

`default_nettype wire
